// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Contents:
//   SEG_ORDER   : bit order of every glyph, for readers and debug printouts
//   SEG_BLANK   : all segments off
//   HEX_FONT    : 16-entry active-low hex font
//   font_lookup : nibble -> glyph helper
package seg7_pkg;

  // Glyph bit order, MSB first: {g,f,e,d,c,b,a}. A 0 bit lights the segment.
  localparam string SEG_ORDER = "gfedcba";

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] glyph_t;

  localparam glyph_t SEG_BLANK = 7'h7F;

  localparam glyph_t HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  function automatic glyph_t font_lookup(input nibble_t n);
    return HEX_FONT[n];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data and display drive bundle of the scan driver.
// Inputs to the driver : value, dp_in, blank_mask, lz_en
// Outputs of the driver: an, seg, dp, digit_idx, load_pulse
// modport slave is the driver side, modport master the producer/observer side.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_en;

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    load_pulse;

  modport master (
    output value, dp_in, blank_mask, lz_en,
    input  an, seg, dp, digit_idx, load_pulse
  );

  modport slave (
    input  value, dp_in, blank_mask, lz_en,
    output an, seg, dp, digit_idx, load_pulse
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low seven-segment glyph decode.
// Ports:
//   nibble : 4-bit hex digit
//   glyph  : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  nibble_t nibble,
  output glyph_t  glyph
);

  assign glyph = font_lookup(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. scan_clk is a slow timing reference
// from the clock divider: it is synchronised into in_clk and its rising edge
// advances one digit. Display data is captured once per frame on the wrap
// to digit 0 so a frame never mixes old and new data.
// Ports:
//   in_clk   : system clock
//   rst      : asynchronous active-high reset
//   scan_clk : slow refresh square wave, asynchronous to in_clk
//   bus      : display data in, anode/segment/dp drive out, digit_idx, load_pulse
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic               scan_clk,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned      IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_DIGITS - 1);

  // Synchroniser and rising-edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   step;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Digit counter, active flag and shadow registers
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    active_q, active_d;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic                    lz_sh_q, lz_sh_d;

  assign wrap = step & (idx_q == LAST);

  always_comb begin
    idx_d      = idx_q;
    active_d   = active_q | wrap;
    val_sh_d   = val_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    lz_sh_d    = lz_sh_q;
    if (step) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      val_sh_d   = bus.value;
      dp_sh_d    = bus.dp_in;
      blank_sh_d = bus.blank_mask;
      lz_sh_d    = bus.lz_en;
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      idx_q      <= LAST;
      active_q   <= 1'b0;
      val_sh_q   <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      lz_sh_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      active_q   <= active_d;
      val_sh_q   <= val_sh_d;
      dp_sh_q    <= dp_sh_d;
      blank_sh_q <= blank_sh_d;
      lz_sh_q    <= lz_sh_d;
    end
  end

  // Output decode works on next-state values so the registered outputs
  // change on the same edge as digit_idx and the shadow reload.
  nibble_t nib;
  glyph_t  glyph;
  logic    upper_zero;
  logic    dark;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  glyph_t                seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  load_q;

  assign nib = val_sh_d[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_font (
    .nibble (nib),
    .glyph  (glyph)
  );

  always_comb begin
    // Nibbles from the current digit up to the most significant one
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_d)) && (val_sh_d[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 is excluded so an all-zero value still shows a single 0
    dark = blank_sh_d[idx_d] | (lz_sh_d & (idx_d != '0) & upper_zero);

    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (active_d && !dark) begin
      an_d[idx_d] = 1'b0;
      seg_d       = glyph;
      dp_d        = ~dp_sh_d[idx_d];
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      load_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      load_q <= wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = idx_q;
  assign bus.load_pulse = load_q;

endmodule
